bitonic_sort_seq: RTL and testbench

BITONIC_SORT_SEQ -- requirements
Module: bitonic_sort_seq

---
 rtl/bitonic_sort_seq.sv | 163 ++++++++++++++++
 tb/tb_bitonic_sort_seq.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bitonic_sort_seq.sv
// Folded bitonic sorter: one K/2-comparator stage per clock, reused across all stages.
// Optional duplicate-flag output enabled by macro BITONIC_SORT_SEQ_DUP_FLAG_EN.
module bitonic_sort_seq #(
    parameter int W = 32,
    parameter int K = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [W*K-1:0] in_array,
    input  logic           dir,
    input  logic           in_valid,
    output logic           in_ready,
    output logic [W*K-1:0] out_array,
    output logic           out_valid,
    input  logic           out_ready,
    output logic           busy
`ifdef BITONIC_SORT_SEQ_DUP_FLAG_EN
    ,
    output logic [K-1:0]   dup
`endif
);

    localparam int L  = $clog2(K);
    localparam int S  = (L * (L + 1)) / 2;
    localparam int CW = (L > 1) ? $clog2(L) : 1;
    localparam int IW = (K > 1) ? L : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SORT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                r_state;
    logic [K-1:0][W-1:0]   r_arr;
    logic [K-1:0][W-1:0]   w_next;
    logic                  r_dir;
    logic [CW-1:0]         r_pm1;
    logic [CW-1:0]         r_dlog;
    logic                  r_in_ready;
    logic                  r_out_valid;
    logic                  r_busy;
    logic                  w_last;

    function automatic logic need_swap(input logic [W-1:0] a_lo, input logic [W-1:0] b_hi,
                                       input logic asc);
        logic sw;
        if (asc) begin
            sw = (a_lo > b_hi);
        end else begin
            sw = (a_lo < b_hi);
        end
        return sw;
    endfunction

    // One comparator stage (phase r_pm1+1, distance 2^r_dlog) applied to the working array.
    // The final phase sees bit p of every index clear, so there the pair direction is r_dir.
    always_comb begin
        w_next = r_arr;
        for (int i = 0; i < K; i++) begin
            logic [IW-1:0] idx;
            logic [IW-1:0] mask;
            logic [IW-1:0] lo;
            logic [IW-1:0] hi;
            logic [31:0]   iv;
            logic          asc;
            logic          sw;
            idx  = IW'(i);
            mask = IW'(1) << r_dlog;
            lo   = idx & ~mask;
            hi   = idx | mask;
            iv   = 32'(i) >> (32'(r_pm1) + 32'd1);
            asc  = iv[0] ^ r_dir;
            sw   = need_swap(r_arr[lo], r_arr[hi], asc);
            if (idx == lo) begin
                w_next[i] = sw ? r_arr[hi] : r_arr[lo];
            end else begin
                w_next[i] = sw ? r_arr[lo] : r_arr[hi];
            end
        end
    end

    assign w_last = (r_pm1 == CW'(L - 1)) && (r_dlog == '0);

    // Control FSM, working array and stage counter with registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_arr       <= '0;
            r_dir       <= 1'b0;
            r_pm1       <= '0;
            r_dlog      <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_arr      <= in_array;
                        r_dir      <= dir;
                        r_pm1      <= '0;
                        r_dlog     <= '0;
                        r_in_ready <= 1'b0;
                        if (S == 0) begin
                            r_state     <= DONE;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_state <= SORT;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                SORT: begin
                    r_arr <= w_next;
                    if (w_last) begin
                        r_state     <= DONE;
                        r_busy      <= 1'b0;
                        r_out_valid <= 1'b1;
                    end else if (r_dlog == '0) begin
                        r_pm1  <= r_pm1 + CW'(1);
                        r_dlog <= r_pm1 + CW'(1);
                    end else begin
                        r_dlog <= r_dlog - CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign out_array = r_arr;

`ifdef BITONIC_SORT_SEQ_DUP_FLAG_EN
    logic [K-1:0] w_dup;

    // Neighbour equality flags over the working array.
    always_comb begin
        w_dup = '0;
        for (int i = 1; i < K; i++) begin
            w_dup[i] = (r_arr[i] == r_arr[i-1]);
        end
    end

    assign dup = r_out_valid ? w_dup : '0;
`endif

endmodule

// File: tb/tb_bitonic_sort_seq.sv
// Self-checking bench for bitonic_sort_seq: directed tables for K=8, K=1/K=2 corners,
// and randomized K=16 vectors checked against a plain sort reference.
module tb_bitonic_sort_seq;

    logic         clk;
    logic         rst;
    logic [127:0] t_in;
    logic         t_dir;
    logic [3:0]   ivld;
    logic [3:0]   ordy;
    wire  [3:0]   ir;
    wire  [3:0]   ov;
    wire  [3:0]   bz;
    wire  [63:0]  o8;
    wire  [127:0] o16;
    wire  [15:0]  o1;
    wire  [15:0]  o2;
`ifdef BITONIC_SORT_SEQ_DUP_FLAG_EN
    wire  [7:0]   dup8;
    wire  [15:0]  dup16;
    wire  [0:0]   dup1;
    wire  [1:0]   dup2;
`endif

    int checks = 0;
    int passes = 0;

    bitonic_sort_seq #(.W(8), .K(8)) u8 (
        .clk(clk), .rst(rst), .in_array(t_in[63:0]), .dir(t_dir), .in_valid(ivld[0]),
        .in_ready(ir[0]), .out_array(o8), .out_valid(ov[0]), .out_ready(ordy[0]), .busy(bz[0])
`ifdef BITONIC_SORT_SEQ_DUP_FLAG_EN
        , .dup(dup8)
`endif
    );

    bitonic_sort_seq #(.W(8), .K(16)) u16 (
        .clk(clk), .rst(rst), .in_array(t_in), .dir(t_dir), .in_valid(ivld[1]),
        .in_ready(ir[1]), .out_array(o16), .out_valid(ov[1]), .out_ready(ordy[1]), .busy(bz[1])
`ifdef BITONIC_SORT_SEQ_DUP_FLAG_EN
        , .dup(dup16)
`endif
    );

    bitonic_sort_seq #(.W(16), .K(1)) u1 (
        .clk(clk), .rst(rst), .in_array(t_in[15:0]), .dir(t_dir), .in_valid(ivld[2]),
        .in_ready(ir[2]), .out_array(o1), .out_valid(ov[2]), .out_ready(ordy[2]), .busy(bz[2])
`ifdef BITONIC_SORT_SEQ_DUP_FLAG_EN
        , .dup(dup1)
`endif
    );

    bitonic_sort_seq #(.W(8), .K(2)) u2 (
        .clk(clk), .rst(rst), .in_array(t_in[15:0]), .dir(t_dir), .in_valid(ivld[3]),
        .in_ready(ir[3]), .out_array(o2), .out_valid(ov[3]), .out_ready(ordy[3]), .busy(bz[3])
`ifdef BITONIC_SORT_SEQ_DUP_FLAG_EN
        , .dup(dup2)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] out_of(input int sel);
        case (sel)
            0:       return {64'd0, o8};
            1:       return o16;
            2:       return {112'd0, o1};
            3:       return {112'd0, o2};
            default: return 128'd0;
        endcase
    endfunction

    function automatic logic [15:0] dup_of(input int sel);
`ifdef BITONIC_SORT_SEQ_DUP_FLAG_EN
        case (sel)
            0:       return {8'd0, dup8};
            1:       return dup16;
            default: return 16'd0;
        endcase
`else
        return 16'd0;
`endif
    endfunction

    // Reference: ascending sort of 16 bytes, reversed for descending.
    function automatic logic [127:0] ref_sort(input logic [127:0] v, input logic d);
        int a[16];
        int tmp;
        logic [127:0] r;
        for (int i = 0; i < 16; i++) a[i] = int'(v[i*8 +: 8]);
        for (int i = 0; i < 16; i++)
            for (int j = 0; j < 15 - i; j++)
                if (a[j] > a[j+1]) begin tmp = a[j]; a[j] = a[j+1]; a[j+1] = tmp; end
        r = 128'd0;
        for (int i = 0; i < 16; i++) r[i*8 +: 8] = d ? 8'(a[i]) : 8'(a[15-i]);
        return r;
    endfunction

    function automatic logic [15:0] ref_dup(input logic [127:0] r);
        logic [15:0] f;
        f = 16'd0;
        for (int i = 1; i < 16; i++) f[i] = (r[i*8 +: 8] == r[(i-1)*8 +: 8]);
        return f;
    endfunction

    // One transaction: optional idle stall, accept, wait for completion, hold, release.
    task automatic run(input int sel, input logic [127:0] vin, input logic vdir, input int hold,
                       input int stall, input bit noise, output logic [127:0] vout,
                       output logic [15:0] vdup, output int lat);
        for (int s = 0; s < stall; s++) begin
            ordy[sel] = 1'($urandom);
            step();
        end
        ordy[sel] = 1'b0;
        t_in = vin;
        t_dir = vdir;
        ivld[sel] = 1'b1;
        chk("ready_before_accept", {127'd0, ir[sel]}, 128'd1);
        step();
        ivld[sel] = 1'b0;
        lat = 1;
        while (!ov[sel] && lat < 64) begin
            if (noise) begin
                ivld[sel] = 1'($urandom);
                ordy[sel] = 1'($urandom);
                t_in = {$urandom, $urandom, $urandom, $urandom};
                t_dir = 1'($urandom);
            end
            step();
            lat++;
        end
        ivld[sel] = 1'b0;
        ordy[sel] = 1'b0;
        chk("out_valid_seen", {127'd0, ov[sel]}, 128'd1);
        vout = out_of(sel);
        vdup = dup_of(sel);
        for (int h = 0; h < hold; h++) begin
            step();
            chk("hold_valid", {127'd0, ov[sel]}, 128'd1);
            chk("hold_stable", out_of(sel), vout);
        end
        ordy[sel] = 1'b1;
        step();
        ordy[sel] = 1'b0;
        chk("released_valid_low", {127'd0, ov[sel]}, 128'd0);
        chk("released_ready_high", {127'd0, ir[sel]}, 128'd1);
    endtask

    typedef struct {
        logic [63:0] vin;
        logic        vdir;
        int          hold;
        logic [63:0] vexp;
        logic [7:0]  vdup;
    } vec_t;

    vec_t tbl[6];

    initial begin
        logic [127:0] vout;
        logic [127:0] vin;
        logic [127:0] exp;
        logic [15:0]  vdup;
        logic [127:0] small_mask;
        logic         d;
        int           lat;
        int           acc;
        int           ir_cnt;
        int           bz_cnt;
        int           last_acc;
        int           bad_gap;
        int           spurious;

        tbl[0] = '{64'h04FF000901090307, 1'b1, 0, 64'hFF09090704030100, 8'b0100_0000};
        tbl[1] = '{64'h04FF000901090307, 1'b0, 5, 64'h00010304070909FF, 8'b0000_0100};
        tbl[2] = '{64'h0101010101010101, 1'b1, 0, 64'h0101010101010101, 8'b1111_1110};
        tbl[3] = '{64'h0706050403020100, 1'b0, 0, 64'h0001020304050607, 8'b0000_0000};
        tbl[4] = '{64'h1020304050607080, 1'b1, 1, 64'h8070605040302010, 8'b0000_0000};
        tbl[5] = '{64'h0000000000000000, 1'b0, 0, 64'h0000000000000000, 8'b1111_1110};
        small_mask = {16{8'h03}};

        rst = 1'b1; t_in = 128'd0; t_dir = 1'b0; ivld = 4'd0; ordy = 4'd0;
        step();
        step();
        rst = 1'b0;
        for (int s = 0; s < 4; s++) begin
            chk("reset_in_ready", {127'd0, ir[s]}, 128'd1);
            chk("reset_out_valid", {127'd0, ov[s]}, 128'd0);
            chk("reset_busy", {127'd0, bz[s]}, 128'd0);
            chk("reset_out_array", out_of(s), 128'd0);
        end
        chk("reset_dup", {112'd0, dup_of(0)}, 128'd0);

        // Reset during the third SORT cycle discards the vector.
        t_in = {64'd0, tbl[0].vin}; t_dir = 1'b1; ivld[0] = 1'b1;
        step();
        ivld[0] = 1'b0;
        chk("sort_busy", {127'd0, bz[0]}, 128'd1);
        chk("sort_in_ready_low", {127'd0, ir[0]}, 128'd0);
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_in_ready", {127'd0, ir[0]}, 128'd1);
        chk("midrst_out_valid", {127'd0, ov[0]}, 128'd0);
        chk("midrst_busy", {127'd0, bz[0]}, 128'd0);
        chk("midrst_out_array", out_of(0), 128'd0);
        chk("midrst_dup", {112'd0, dup_of(0)}, 128'd0);
        spurious = 0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (ov[0]) spurious++;
        end
        chk("midrst_no_output", 128'(spurious), 128'd0);

        for (int n = 0; n < 6; n++) begin
            run(0, {64'd0, tbl[n].vin}, tbl[n].vdir, tbl[n].hold, 0, 1'b0, vout, vdup, lat);
            chk("k8_out", vout, {64'd0, tbl[n].vexp});
            chk("k8_latency", 128'(lat), 128'd7);
`ifdef BITONIC_SORT_SEQ_DUP_FLAG_EN
            chk("k8_dup", {112'd0, vdup}, {120'd0, tbl[n].vdup});
`endif
        end

        // Continuous in_valid with out_ready high: one acceptance every 8 cycles.
        t_in = {64'd0, tbl[4].vin}; ivld[0] = 1'b1; ordy[0] = 1'b1;
        acc = 0; ir_cnt = 0; bz_cnt = 0; last_acc = -1; bad_gap = 0;
        for (int e = 0; e < 40; e++) begin
            if (ir[0]) begin
                ir_cnt++;
                acc++;
                if (last_acc >= 0 && e - last_acc != 8) bad_gap++;
                last_acc = e;
            end
            if (bz[0]) bz_cnt++;
            step();
        end
        ivld[0] = 1'b0; ordy[0] = 1'b0;
        chk("tput_accepts", 128'(acc), 128'd5);
        chk("tput_in_ready_cycles", 128'(ir_cnt), 128'd5);
        chk("tput_gap", 128'(bad_gap), 128'd0);
        chk("tput_busy_cycles", 128'(bz_cnt), 128'd30);

        run(2, 128'h0BEEF, 1'b1, 0, 0, 1'b0, vout, vdup, lat);
        chk("k1_out", vout, 128'h0BEEF);
        chk("k1_latency", 128'(lat), 128'd1);
        run(3, 128'h0205, 1'b1, 0, 0, 1'b0, vout, vdup, lat);
        chk("k2_asc_out", vout, 128'h0502);
        chk("k2_latency", 128'(lat), 128'd2);
        run(3, 128'h0502, 1'b0, 0, 0, 1'b0, vout, vdup, lat);
        chk("k2_desc_out", vout, 128'h0205);

        for (int n = 0; n < 1500; n++) begin
            vin = {$urandom, $urandom, $urandom, $urandom};
            if ($urandom_range(0, 1) == 0) vin = vin & small_mask;
            d = 1'($urandom);
            exp = ref_sort(vin, d);
            run(1, vin, d, $urandom_range(0, 2), $urandom_range(0, 3), 1'b1, vout, vdup, lat);
            chk("k16_out", vout, exp);
            chk("k16_latency", 128'(lat), 128'd11);
`ifdef BITONIC_SORT_SEQ_DUP_FLAG_EN
            chk("k16_dup", {112'd0, vdup}, {112'd0, ref_dup(exp)});
`endif
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
